// File: rtl/mult_control.sv
// Sequencer for a shift-and-add multiplier: issues Load/Ad/Sh to the accumulator,
// examines the multiplier LSB once per iteration and handshakes completion via St/Done.
module mult_control #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic St,
  input  logic M,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Busy,
  output logic Done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;

  // State register and iteration counter
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD)
        cnt <= '0;
      else if (state == SHIFT && cnt != CNT_LAST)
        cnt <= cnt + CW'(1);
    end
  end

  // TEST is the only state that looks at M: the accumulator LSB settles one
  // cycle after each Load/Ad/Sh edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (St) state_nxt = LOAD;
      LOAD:    state_nxt = TEST;
      TEST:    state_nxt = M ? ADD : SHIFT;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt == CNT_LAST) ? DONE : TEST;
      DONE:    if (!St) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs, decoded from the registered state only
  always_comb begin
    Load = 1'b0;
    Ad   = 1'b0;
    Sh   = 1'b0;
    Busy = 1'b0;
    Done = 1'b0;
    case (state)
      LOAD:    begin Load = 1'b1; Busy = 1'b1; end
      TEST:    Busy = 1'b1;
      ADD:     begin Ad = 1'b1; Busy = 1'b1; end
      SHIFT:   begin Sh = 1'b1; Busy = 1'b1; end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Scoreboard bench for mult_control paired with a behavioural accumulator; expected
// command strings, Done timing and products are derived from the multiplier value.
module tb_mult_control;
  localparam int N = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic St  = 1'b0;
  logic M;
  logic Load, Ad, Sh, Busy, Done;

  logic [N-1:0] mcand  = '0;
  logic [N-1:0] mplier = '0;
  logic [2*N:0] acc    = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  string exp_cmds[$];
  int    exp_done[$];
  int    exp_prod[$];

  mult_control #(.N(N)) dut (
    .Clk(Clk), .Rst(Rst), .St(St), .M(M),
    .Load(Load), .Ad(Ad), .Sh(Sh), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Accumulator model: {carry, A, multiplier}, M is its LSB
  always @(posedge Clk) begin
    if (Load)
      acc <= {(N+1)'(0), mplier};
    else if (Ad)
      acc[2*N:N] <= {1'b0, acc[2*N-1:N]} + {1'b0, mcand};
    else if (Sh)
      acc <= acc >> 1;
  end
  assign M = acc[0];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic string cmds_for(input logic [N-1:0] mp);
    string s;
    s = "L";
    for (int i = 0; i < N; i++) begin
      if (mp[i]) s = {s, "AS"};
      else       s = {s, "S"};
    end
    return s;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the LOAD cycle.
  task automatic start_op(input logic [N-1:0] mc, input logic [N-1:0] mp, output int c0);
    int lat;
    mcand  = mc;
    mplier = mp;
    St     = 1'b1;
    Rst    = 1'b1;
    @(posedge Clk);
    #1;
    c0  = cyc;
    lat = 2 + 2*N + $countones(mp);
    exp_cmds.push_back(cmds_for(mp));
    exp_done.push_back(c0 + lat - 1);
    exp_prod.push_back(int'(mc) * int'(mp));
    @(negedge Clk);
    chk("load_after_start", int'({Load, Busy}), 3);
  endtask

  // Random St noise while busy, then hold St high for 'hold' Done cycles and release.
  task automatic finish_op(input logic [N-1:0] mp, input int hold);
    int lat;
    lat = 2 + 2*N + $countones(mp);
    for (int k = 0; k < lat - 1; k++) begin
      St = 1'($urandom);
      @(negedge Clk);
    end
    for (int i = 0; i < hold; i++) begin
      St = 1'b1;
      @(negedge Clk);
      chk("done_hold", int'({Done, Load, Busy}), 4);
    end
    St = 1'b0;
    @(negedge Clk);
    chk("idle_after_release", int'({Load, Ad, Sh, Busy, Done}), 0);
  endtask

  task automatic run_op(input logic [N-1:0] mc, input logic [N-1:0] mp, input int hold);
    int c0;
    start_op(mc, mp, c0);
    finish_op(mp, hold);
  endtask

  // Monitor: per-cycle command legality plus scoreboard pop on each Done rise
  initial begin
    string seen;
    logic  done_q;
    string ec;
    int    ed, ep;
    seen   = "";
    done_q = 1'b0;
    forever begin
      @(negedge Clk);
      chk("one_hot_cmd", int'(Load) + int'(Ad) + int'(Sh) > 1 ? 1 : 0, 0);
      chk("busy_done_excl", int'(Busy & Done), 0);
      if (Load) seen = "";
      if (Load) seen = {seen, "L"};
      if (Ad)   seen = {seen, "A"};
      if (Sh)   seen = {seen, "S"};
      if (Done && !done_q) begin
        if (exp_cmds.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ec = exp_cmds.pop_front();
          ed = exp_done.pop_front();
          ep = exp_prod.pop_front();
          checks++;
          if (seen != ec) begin
            errors++;
            $display("FAIL cmd_seq: got %s, expected %s", seen, ec);
          end
          chk("done_cycle", cyc, ed);
          chk("product", int'(acc), ep);
        end
      end
      done_q = Done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n_ad;
    // Reset held with St high: nothing may start
    Rst = 1'b0;
    St  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("reset_outputs", int'({Load, Ad, Sh, Busy, Done}), 0);
    end
    // Releasing reset with St still high starts immediately
    run_op(4'b1101, 4'b1011, 5);   // 13 x 11 = 143
    run_op(4'b1011, 4'b1101, 1);
    run_op(4'b0111, 4'b0000, 2);
    run_op(4'b1111, 4'b1111, 5);
    run_op(4'b0000, 4'b1001, 0);

    // Abort on the second ADD, then a clean full-length operation
    start_op(4'b1010, 4'b1111, c0);
    n_ad = 0;
    for (int k = 0; k < 20 && n_ad < 2; k++) begin
      if (Ad) n_ad++;
      if (n_ad < 2) begin
        St = 1'($urandom);
        @(negedge Clk);
      end
    end
    chk("second_add_reached", n_ad, 2);
    Rst = 1'b0;
    @(negedge Clk);
    chk("abort_outputs", int'({Load, Ad, Sh, Busy, Done}), 0);
    void'(exp_cmds.pop_back());
    void'(exp_done.pop_back());
    void'(exp_prod.pop_back());
    St  = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    chk("idle_after_abort", int'({Load, Busy, Done}), 0);
    run_op(4'b0110, 4'b0000, 1);
    run_op(4'b1001, 4'b1111, 3);

    for (int i = 0; i < 30; i++)
      run_op(N'($urandom), N'($urandom), int'($urandom_range(0, 5)));

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", exp_cmds.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
